key_emulator: RTL and testbench
===============================

KEY_EMULATOR -- requirements
Module: key_emulator

Interface
REQ-001 SHALL have parameter GAP_INTERVAL, default 1000: minimum cycles KEY is held released between successive presses.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of queued press commands; power of two, at least 2.
REQ-003 SHALL have parameter DUR_WIDTH, default 32: width of the hold-duration field.
REQ-004 SHALL have port clock, input, 1: sole clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1: a press command is offered.
REQ-007 SHALL have port cmd_ready, output, 1: the command FIFO can accept a command.
REQ-008 SHALL have port cmd_hold, input, DUR_WIDTH: number of cycles KEY is driven low for the offered command.
REQ-009 SHALL have port KEY, output, 1: emulated active-low pushbutton level (1 = released, 0 = pressed).
REQ-010 SHALL have port press_done, output, 1: one-cycle pulse when KEY returns high after a press.
REQ-011 SHALL have port busy, output, 1: high while the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-012 A command SHALL be accepted on a posedge where cmd_valid and cmd_ready are both high; cmd_hold SHALL be captured on that edge.
REQ-013 cmd_ready SHALL be exactly !fifo_full, and SHALL not depend on cmd_valid or a same-cycle pop (no full-FIFO bypass).
REQ-014 cmd_valid while cmd_ready is low SHALL be ignored and SHALL NOT modify the FIFO.
REQ-015 The FSM SHALL have three states, IDLE, PRESS and GAP, with the following transitions:
- IDLE to PRESS when the FIFO is non-empty.
- PRESS to GAP when the hold counter expires.
- GAP to PRESS when the gap counter expires and the FIFO is non-empty.
- GAP to IDLE when the gap counter expires and the FIFO is empty.
REQ-016 On the IDLE-to-PRESS transition, the FSM SHALL pop the FIFO head and load the hold counter with max(cmd_hold, 1); a hold of 0 SHALL be treated as 1.
REQ-017 KEY SHALL be registered; with IDLE and an empty FIFO, a command accepted at edge E0 SHALL make KEY fall at edge E0+1.
REQ-018 KEY SHALL stay low for exactly N cycles, where N is the effective hold, and SHALL rise at edge E0+1+N.
REQ-019 press_done SHALL be high for exactly the one cycle after KEY rises.
REQ-020 In GAP, KEY SHALL stay high for exactly GAP_INTERVAL cycles; the next fall SHALL occur no earlier than rise + GAP_INTERVAL cycles.
REQ-021 The next fall SHALL occur exactly at rise + GAP_INTERVAL when a command is already queued.
REQ-022 A push and a pop on the same edge SHALL leave the FIFO occupancy unchanged and SHALL preserve command order.
REQ-023 Counters SHALL be DUR_WIDTH bits wide, SHALL count down and SHALL NOT wrap; the maximum hold SHALL be 2^DUR_WIDTH-1 cycles.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Full and empty SHALL be derived from an occupancy count of width clog2(FIFO_DEPTH)+1.

Reset
REQ-026 On reset: KEY=1, press_done=0, cmd_ready=1, busy=0, FSM=IDLE, FIFO empty, counters=0.
REQ-027 Reset during PRESS SHALL return KEY high on the reset edge, SHALL produce no press_done pulse, and SHALL discard all queued commands.
REQ-028 A command offered in the same cycle as reset SHALL be discarded.

Structure
REQ-029 The default GAP_INTERVAL, FIFO_DEPTH, DUR_WIDTH and the FSM state encodings SHALL live in the shared key_pkg include; the block SHALL use only those values.
REQ-030 The command queue SHALL be a sub-module key_cmd_fifo (parameters DEPTH and WIDTH; push/pop/full/empty; synchronous reset); the FSM and counters SHALL reside in key_emulator.

Verification (bench overrides: GAP_INTERVAL=4, FIFO_DEPTH=4)
REQ-031 Single press: accept hold=5 at E0 -> KEY low for edges E1 through E5 and high from E6; press_done high only in the cycle after E6; busy low after E6+4.
REQ-032 Back-to-back: accept holds 3 and 2 on consecutive cycles -> KEY low 3 cycles, high exactly 4 cycles, low 2 cycles; two press_done pulses, 6 cycles apart.
REQ-033 Full FIFO: hold the FSM in PRESS (hold=100) and offer 6 commands -> exactly 4 accepted, cmd_ready=0 afterwards, cmd_ready=1 the cycle after the first pop; accepted commands played back in order.
REQ-034 Zero hold: accept hold=0 -> KEY low for exactly 1 cycle, then press_done.
REQ-035 Reset mid-press: with hold=10 and 2 queued, assert reset at cycle 4 of the press -> KEY=1 on the reset edge, no press_done, busy=0, cmd_ready=1, no further KEY activity.
REQ-036 Simultaneous push/pop: at 3/4 occupancy, push on the same edge as a pop -> occupancy stays 3, order preserved, cmd_ready stays 1.

Source files
------------

// File: rtl/key_pkg.sv
// Shared defaults and FSM state encoding for the key emulator block.
package key_pkg;

    localparam int unsigned KEY_GAP_INTERVAL = 1000;
    localparam int unsigned KEY_FIFO_DEPTH   = 4;
    localparam int unsigned KEY_DUR_WIDTH    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } key_state_e;

endpackage

// File: rtl/key_cmd_fifo.sv
// Small command queue: push/pop with full/empty derived from an occupancy count.
module key_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap naturally at AW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/key_emulator.sv
// Pushbutton emulator: plays queued press commands on an active-low KEY line,
// holding KEY released for a fixed gap between successive presses.
module key_emulator
    import key_pkg::*;
#(
    parameter int unsigned GAP_INTERVAL = KEY_GAP_INTERVAL,
    parameter int unsigned FIFO_DEPTH   = KEY_FIFO_DEPTH,
    parameter int unsigned DUR_WIDTH    = KEY_DUR_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [DUR_WIDTH-1:0] cmd_hold,
    output logic                 KEY,
    output logic                 press_done,
    output logic                 busy,
    output logic [1:0]           dbg_state_o
);

    localparam logic [DUR_WIDTH-1:0] ONE      = DUR_WIDTH'(1);
    localparam logic [DUR_WIDTH-1:0] GAP_LOAD = DUR_WIDTH'((GAP_INTERVAL == 0) ? 1 : GAP_INTERVAL);

    // Handshake: a command is taken on a posedge where cmd_valid && cmd_ready;
    // cmd_ready is purely !full and never looks at cmd_valid or a same-cycle pop.
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DUR_WIDTH-1:0] fifo_head;
    logic [DUR_WIDTH-1:0] head_hold;

    key_state_e           state_q, state_d;
    logic [DUR_WIDTH-1:0] cnt_q, cnt_d;
    logic                 key_q, key_d;
    logic                 done_q, done_d;

    assign cmd_ready   = !fifo_full;
    assign fifo_push   = cmd_valid && cmd_ready;
    assign head_hold   = (fifo_head == '0) ? ONE : fifo_head;
    assign KEY         = key_q;
    assign press_done  = done_q;
    assign busy        = !fifo_empty || (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

    key_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DUR_WIDTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (cmd_hold),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d  = ST_PRESS;
                    fifo_pop = 1'b1;
                    cnt_d    = head_hold;
                    key_d    = 1'b0;
                end
            end
            ST_PRESS: begin
                if (cnt_q <= ONE) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                    key_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_GAP: begin
                // Gap expiry with a queued command goes straight into the next press.
                if (cnt_q <= ONE) begin
                    if (!fifo_empty) begin
                        state_d  = ST_PRESS;
                        fifo_pop = 1'b1;
                        cnt_d    = head_hold;
                        key_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                key_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_key_emulator.sv
// Directed bench for key_emulator with GAP_INTERVAL=4, FIFO_DEPTH=4.
module tb_key_emulator;
    import key_pkg::*;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_hold;
    logic        KEY;
    logic        press_done;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    int ek [11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    int ed [11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

    key_emulator #(
        .GAP_INTERVAL (4),
        .FIFO_DEPTH   (4),
        .DUR_WIDTH    (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_hold    (cmd_hold),
        .KEY         (KEY),
        .press_done  (press_done),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rise(input int start, output int low);
        bit seen;
        seen = 1'b0;
        low  = start;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            if (KEY === 1'b1) seen = 1'b1;
            else low++;
        end
        if (!seen) low = -1;
    endtask

    task automatic wait_fall(output int gap);
        bit seen;
        seen = 1'b0;
        gap  = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step();
            gap++;
            if (KEY === 1'b0) seen = 1'b1;
        end
        if (!seen) gap = -1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50 && busy !== 1'b0; i++) step();
        check(tag, busy, 0);
    endtask

    initial begin
        int  low;
        int  gap;
        bit  activity;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_hold  = '0;
        step();
        step();
        check("rst_key", KEY, 1);
        check("rst_done", press_done, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        step();

        // Single press, hold 5
        cmd_valid = 1'b1;
        cmd_hold  = 5;
        step();
        cmd_valid = 1'b0;
        check("single_e0_key", KEY, 1);
        check("single_e0_busy", busy, 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("single_key_low", KEY, 0);
            check("single_done_low", press_done, 0);
        end
        step();
        check("single_rise_key", KEY, 1);
        check("single_rise_done", press_done, 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("single_gap_done", press_done, 0);
            check("single_gap_busy", busy, 1);
        end
        step();
        check("single_idle_busy", busy, 0);
        check("single_idle_state", dbg_state, ST_IDLE);

        // Back-to-back holds 3 and 2
        cmd_valid = 1'b1;
        cmd_hold  = 3;
        step();
        cmd_hold  = 2;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) step();
            check("b2b_key", KEY, ek[k-1]);
            check("b2b_done", press_done, ed[k-1]);
        end
        wait_idle("b2b_idle");

        // Zero hold behaves as one cycle
        cmd_valid = 1'b1;
        cmd_hold  = 0;
        step();
        cmd_valid = 1'b0;
        step();
        check("zero_key_low", KEY, 0);
        step();
        check("zero_key_high", KEY, 1);
        check("zero_done", press_done, 1);
        wait_idle("zero_idle");

        // Full FIFO while a long press is in progress
        cmd_valid = 1'b1;
        cmd_hold  = 100;
        step();
        cmd_valid = 1'b0;
        step();
        check("full_press_key", KEY, 0);
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_hold  = 11 + i;
            check("full_ready_offer", cmd_ready, (i < 4) ? 1 : 0);
            step();
        end
        cmd_valid = 1'b0;
        check("full_ready_after", cmd_ready, 0);
        wait_rise(7, low);
        check("full_hold100", low, 100);
        check("full_done", press_done, 1);
        for (int g = 1; g <= 3; g++) begin
            step();
            check("full_gap_ready", cmd_ready, 0);
            check("full_gap_key", KEY, 1);
        end
        step();
        check("full_pop_key", KEY, 0);
        check("full_pop_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_fall(gap);
                check("full_gap_len", gap, 4);
            end
            wait_rise(1, low);
            check("full_order_hold", low, 11 + i);
        end
        wait_idle("full_idle");

        // Push and pop on the same edge at occupancy 3
        cmd_valid = 1'b1;
        cmd_hold  = 6;
        step();
        cmd_hold  = 2;
        step();
        cmd_hold  = 3;
        step();
        cmd_hold  = 4;
        step();
        cmd_valid = 1'b0;
        wait_rise(3, low);
        check("pp_hold_a", low, 6);
        step();
        step();
        step();
        cmd_valid = 1'b1;
        cmd_hold  = 5;
        check("pp_ready_before", cmd_ready, 1);
        step();
        check("pp_key_fall", KEY, 0);
        check("pp_ready_same", cmd_ready, 1);
        cmd_hold = 6;
        step();
        cmd_valid = 1'b0;
        check("pp_ready_full", cmd_ready, 0);
        wait_rise(2, low);
        check("pp_hold_b", low, 2);
        for (int h = 3; h <= 6; h++) begin
            wait_fall(gap);
            check("pp_gap_len", gap, 4);
            wait_rise(1, low);
            check("pp_order_hold", low, h);
        end
        wait_idle("pp_idle");

        // Reset in the middle of a press with two commands queued
        cmd_valid = 1'b1;
        cmd_hold  = 10;
        step();
        cmd_hold  = 7;
        step();
        cmd_hold  = 8;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_key_low", KEY, 0);
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_hold  = 9;
        step();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        check("mid_rst_key", KEY, 1);
        check("mid_rst_done", press_done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_state", dbg_state, ST_IDLE);
        activity = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (KEY !== 1'b1 || press_done !== 1'b0 || busy !== 1'b0) activity = 1'b1;
        end
        check("mid_quiet", activity, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
